// File: rtl/uart_rcvr.sv
// uart_rcvr: oversampled UART receive path with 2-flop line synchronizer.
// Start bit is validated to its centre, then every bit is sampled mid-cell.
module uart_rcvr #(
  parameter int WORD_SIZE  = 8,
  parameter int OVERSAMPLE = 8
) (
  input  logic                 Clock,
  input  logic                 rst_b,
  input  logic                 Serial_in,
  input  logic                 read_not_ready_in,
  output logic [WORD_SIZE-1:0] RCV_datareg,
  output logic                 read_not_ready_out,
  output logic                 Error1,
  output logic                 Error2
);

  localparam int HALF = OVERSAMPLE / 2;
  localparam int SW   = $clog2(OVERSAMPLE);
  localparam int BW   = $clog2(WORD_SIZE + 1);

  localparam logic [SW-1:0] S_MID  = SW'(HALF - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_STOP = BW'(WORD_SIZE);

  typedef enum logic [1:0] {
    IDLE,
    STARTING,
    RECEIVING
  } state_t;

  state_t state, state_nx;

  logic                 s1;
  logic                 ser_s;
  logic [SW-1:0]        scnt, scnt_nx;
  logic [BW-1:0]        bcnt, bcnt_nx;
  logic [WORD_SIZE-1:0] shreg, shreg_nx;
  logic [WORD_SIZE-1:0] data_nx;
  logic                 rdy_nx;
  logic                 e1_nx;
  logic                 e2_nx;

  always_ff @(posedge Clock or negedge rst_b) begin
    if (!rst_b) begin
      s1    <= 1'b1;
      ser_s <= 1'b1;
    end else begin
      s1    <= Serial_in;
      ser_s <= s1;
    end
  end

  always_ff @(posedge Clock or negedge rst_b) begin
    if (!rst_b) begin
      state              <= IDLE;
      scnt               <= '0;
      bcnt               <= '0;
      shreg              <= '0;
      RCV_datareg        <= '0;
      read_not_ready_out <= 1'b0;
      Error1             <= 1'b0;
      Error2             <= 1'b0;
    end else begin
      state              <= state_nx;
      scnt               <= scnt_nx;
      bcnt               <= bcnt_nx;
      shreg              <= shreg_nx;
      RCV_datareg        <= data_nx;
      read_not_ready_out <= rdy_nx;
      Error1             <= e1_nx;
      Error2             <= e2_nx;
    end
  end

  always_comb begin
    state_nx = state;
    scnt_nx  = scnt;
    bcnt_nx  = bcnt;
    shreg_nx = shreg;
    data_nx  = RCV_datareg;
    rdy_nx   = 1'b0;
    e1_nx    = 1'b0;
    e2_nx    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!ser_s) begin
          state_nx = STARTING;
          scnt_nx  = '0;
        end
      end
      STARTING: begin
        if (ser_s) begin
          state_nx = IDLE;
          scnt_nx  = '0;
        end else if (scnt == S_MID) begin
          state_nx = RECEIVING;
          scnt_nx  = '0;
        end else begin
          scnt_nx = scnt + SW'(1);
        end
      end
      RECEIVING: begin
        if (scnt != S_LAST) begin
          scnt_nx = scnt + SW'(1);
        end else begin
          scnt_nx = '0;
          if (bcnt != B_STOP) begin
            // first data bit shifts all the way down to bit 0
            shreg_nx = (shreg >> 1)
                     | (WORD_SIZE'(ser_s) << (WORD_SIZE - 1));
            bcnt_nx  = bcnt + BW'(1);
          end else begin
            state_nx = IDLE;
            bcnt_nx  = '0;
            if (read_not_ready_in) begin
              e1_nx = 1'b1;
            end else if (!ser_s) begin
              e2_nx = 1'b1;
            end else begin
              data_nx = shreg;
              rdy_nx  = 1'b1;
            end
          end
        end
      end
      default: begin
        state_nx = IDLE;
        scnt_nx  = '0;
        bcnt_nx  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rcvr.sv
// tb_uart_rcvr: random and directed frames against a frame-level
// scoreboard that predicts each outcome from the start-edge cycle.
module tb_uart_rcvr;

  localparam int W   = 8;
  localparam int OS  = 8;
  localparam int LAT = 2 + OS / 2 + OS * (W + 1);

  logic         Clock = 1'b0;
  logic         rst_b;
  logic         Serial_in;
  logic         read_not_ready_in;
  logic [W-1:0] RCV_datareg;
  logic         read_not_ready_out;
  logic         Error1;
  logic         Error2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // kind: 1 = good word, 2 = overrun, 3 = framing
  int           exp_kind[int];
  logic [W-1:0] exp_word[int];
  logic [W-1:0] exp_data = '0;
  int           n_ok_exp  = 0;
  int           n_ok_seen = 0;

  uart_rcvr #(
    .WORD_SIZE  (W),
    .OVERSAMPLE (OS)
  ) dut (
    .Clock              (Clock),
    .rst_b              (rst_b),
    .Serial_in          (Serial_in),
    .read_not_ready_in  (read_not_ready_in),
    .RCV_datareg        (RCV_datareg),
    .read_not_ready_out (read_not_ready_out),
    .Error1             (Error1),
    .Error2             (Error2)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h",
               tag, cyc, got, exp);
    end
  endtask

  always @(negedge Clock) begin : mon
    int k;
    k = exp_kind.exists(cyc) ? exp_kind[cyc] : 0;
    if (k == 1) exp_data = exp_word[cyc];
    if (read_not_ready_out) n_ok_seen++;
    check("rdy",  {31'd0, read_not_ready_out}, {31'd0, k == 1});
    check("err1", {31'd0, Error1}, {31'd0, k == 2});
    check("err2", {31'd0, Error2}, {31'd0, k == 3});
    check("data", 32'(RCV_datareg), 32'(exp_data));
  end

  task automatic hold(input logic b, input int n);
    repeat (n) begin
      @(negedge Clock);
      #1 Serial_in = b;
    end
  endtask

  task automatic send(input logic [W-1:0] d, input logic stop,
                      input logic rnr, input int gap);
    int e;
    @(negedge Clock);
    #1;
    Serial_in         = 1'b0;
    read_not_ready_in = rnr;
    e = cyc + 1;
    exp_kind[e + LAT] = rnr ? 2 : (stop ? 1 : 3);
    exp_word[e + LAT] = d;
    if (!rnr && stop) n_ok_exp++;
    hold(1'b0, OS - 1);
    for (int i = 0; i < W; i++) hold(d[i], OS);
    hold(stop, OS);
    hold(1'b1, gap * OS);
  endtask

  task automatic glitch(input int n);
    @(negedge Clock);
    #1 Serial_in = 1'b0;
    hold(1'b0, n - 1);
    hold(1'b1, 2 * OS);
  endtask

  task automatic abort_frame(input logic [W-1:0] d);
    @(negedge Clock);
    #1;
    Serial_in         = 1'b0;
    read_not_ready_in = 1'b0;
    hold(1'b0, OS - 1);
    for (int i = 0; i < 4; i++) hold(d[i], OS);
    hold(d[4], 3);
    @(negedge Clock);
    #1;
    rst_b     = 1'b0;
    Serial_in = 1'b1;
    exp_data  = '0;
    #1;
    check("rst_now",
          {20'd0, RCV_datareg, read_not_ready_out, Error1, Error2, 1'b0},
          32'd0);
    @(negedge Clock);
    #1 rst_b = 1'b1;
    hold(1'b1, 2 * OS);
  endtask

  initial begin
    logic [W-1:0] d;
    logic         stop;
    logic         rnr;
    int           gap;
    rst_b             = 1'b0;
    Serial_in         = 1'b1;
    read_not_ready_in = 1'b0;
    repeat (3) @(negedge Clock);
    check("rst_state",
          {20'd0, RCV_datareg, read_not_ready_out, Error1, Error2, 1'b0},
          32'd0);
    #1 rst_b = 1'b1;
    hold(1'b1, 2 * OS);

    send(8'hA5, 1'b1, 1'b0, 1);
    glitch(3);
    send(8'h3C, 1'b0, 1'b0, 1);
    send(8'h5A, 1'b1, 1'b0, 1);
    send(8'h81, 1'b0, 1'b1, 1);
    send(8'h00, 1'b1, 1'b0, 0);
    send(8'hFF, 1'b1, 1'b0, 1);
    abort_frame(8'h33);
    send(8'h96, 1'b1, 1'b0, 1);

    for (int i = 0; i < 40; i++) begin
      d    = W'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      rnr  = ($urandom_range(0, 4) == 0);
      gap  = $urandom_range(0, 2);
      if (!stop && gap == 0) gap = 1;
      if ($urandom_range(0, 5) == 0) glitch($urandom_range(1, 3));
      send(d, stop, rnr, gap);
    end

    hold(1'b1, 100);
    check("ok_count", n_ok_seen, n_ok_exp);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
